// File: rtl/sc_reg_posjug1_pkg.sv
// Shared game definitions: bus width, default start position, FSM/direction
// encodings and the repeat-counter sizing helper.
package sc_reg_posjug1_pkg;

  localparam int         GAME_BUS_W    = 8;
  localparam logic [7:0] GAME_INIT_POS = 8'b0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } fsm_state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  typedef struct packed {
    fsm_state_e st;
    dir_e       dir;
  } fsm_reg_t;

  // Counter must hold max(a, b) - 1; never narrower than one bit.
  function automatic int sc_cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sc_counter_repeat.sv
// Loadable down-counter with terminal-count flag; saturates at zero.
// Shared between the player repeat timer and the obstacle-row shift timer.
module sc_counter_repeat #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear beats load beats decrement.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - ONE_C;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/sc_reg_posjug1.sv
// Player-1 one-hot position register: sampled active-low buttons drive
// single-step moves, hold-to-repeat, edge saturation and enable freeze.
import sc_reg_posjug1_pkg::*;

module sc_reg_posjug1 #(
  parameter int                   DATAWIDTH     = GAME_BUS_W,
  parameter logic [DATAWIDTH-1:0] INIT_POS      = DATAWIDTH'(GAME_INIT_POS),
  parameter int                   REPEAT_DELAY  = 25000000,
  parameter int                   REPEAT_PERIOD = 10000000
) (
  input  logic                 SC_RegPOSJUG1_CLOCK_50,
  input  logic                 SC_RegPOSJUG1_RESET_InHigh,
  input  logic                 SC_RegPOSJUG1_enable_InHigh,
  input  logic                 SC_RegPOSJUG1_clear_InHigh,
  input  logic                 SC_RegPOSJUG1_left_InLow,
  input  logic                 SC_RegPOSJUG1_right_InLow,
  output logic [DATAWIDTH-1:0] SC_RegPOSJUG1_posjug1_OutBUS,
  output logic                 SC_RegPOSJUG1_moved_OutHigh,
  output logic                 SC_RegPOSJUG1_atEdge_OutHigh
);

  localparam int               CNT_W       = sc_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
  localparam fsm_reg_t         FSM_IDLE_C  = '{st: ST_IDLE, dir: DIR_RIGHT};

  logic                 left_smp_q;
  logic                 right_smp_q;
  fsm_reg_t             fsm_q;
  fsm_reg_t             fsm_d;
  logic [DATAWIDTH-1:0] pos_q;
  logic [DATAWIDTH-1:0] pos_d;
  logic                 moved_q;
  logic                 moved_d;

  logic                 req_valid_s;
  dir_e                 req_dir_s;
  logic                 pos_ok_s;
  logic                 cnt_clr_s;
  logic                 cnt_load_s;
  logic                 cnt_dec_s;
  logic [CNT_W-1:0]     cnt_val_s;
  logic                 cnt_tc_s;

  function automatic logic [DATAWIDTH-1:0] step_pos(input logic [DATAWIDTH-1:0] p,
                                                    input dir_e d);
    logic [DATAWIDTH-1:0] r;
    if (d == DIR_LEFT) begin
      if (p[DATAWIDTH-1]) r = p;
      else                r = p << 1'b1;
    end else begin
      if (p[0]) r = p;
      else      r = p >> 1'b1;
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [DATAWIDTH-1:0] p);
    logic seen;
    logic bad;
    seen = 1'b0;
    bad  = 1'b0;
    for (int i = 0; i < DATAWIDTH; i++) begin
      if (p[i] && seen) bad = 1'b1;
      if (p[i])         seen = 1'b1;
    end
    return seen & ~bad;
  endfunction

  // Decode the sampled buttons into a single-direction request.
  always_comb begin
    req_valid_s = left_smp_q ^ right_smp_q;
    if (!left_smp_q) begin
      req_dir_s = DIR_LEFT;
    end else begin
      req_dir_s = DIR_RIGHT;
    end
    pos_ok_s = is_onehot(pos_q);
  end

  // Move FSM; a corrupted position bus is reloaded so the bus never leaves one-hot.
  always_comb begin
    fsm_d      = fsm_q;
    pos_d      = pos_q;
    moved_d    = 1'b0;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_val_s  = '0;
    if (SC_RegPOSJUG1_clear_InHigh) begin
      pos_d     = INIT_POS;
      fsm_d     = FSM_IDLE_C;
      cnt_clr_s = 1'b1;
    end else if (!pos_ok_s) begin
      pos_d     = INIT_POS;
      fsm_d     = FSM_IDLE_C;
      cnt_clr_s = 1'b1;
      moved_d   = 1'b1;
    end else if (!SC_RegPOSJUG1_enable_InHigh) begin
      fsm_d     = FSM_IDLE_C;
      cnt_clr_s = 1'b1;
    end else begin
      case (fsm_q.st)
        ST_IDLE: begin
          if (req_valid_s) begin
            pos_d      = step_pos(pos_q, req_dir_s);
            fsm_d.st   = ST_DELAY;
            fsm_d.dir  = req_dir_s;
            cnt_load_s = 1'b1;
            cnt_val_s  = DELAY_LOAD;
          end else begin
            fsm_d = fsm_q;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (req_valid_s && (req_dir_s == fsm_q.dir)) begin
            if (cnt_tc_s) begin
              pos_d      = step_pos(pos_q, fsm_q.dir);
              fsm_d.st   = ST_REPEAT;
              cnt_load_s = 1'b1;
              cnt_val_s  = PERIOD_LOAD;
            end else begin
              cnt_dec_s = 1'b1;
            end
          end else begin
            // Any break in the hold returns to IDLE without moving.
            fsm_d.st  = ST_IDLE;
            cnt_clr_s = 1'b1;
          end
        end
        default: begin
          fsm_d     = FSM_IDLE_C;
          cnt_clr_s = 1'b1;
        end
      endcase
      moved_d = (pos_d != pos_q);
    end
  end

  // Sample stage and state registers.
  always_ff @(posedge SC_RegPOSJUG1_CLOCK_50) begin
    if (SC_RegPOSJUG1_RESET_InHigh) begin
      left_smp_q  <= 1'b1;
      right_smp_q <= 1'b1;
      fsm_q       <= FSM_IDLE_C;
      pos_q       <= INIT_POS;
      moved_q     <= 1'b0;
    end else begin
      left_smp_q  <= SC_RegPOSJUG1_left_InLow;
      right_smp_q <= SC_RegPOSJUG1_right_InLow;
      fsm_q       <= fsm_d;
      pos_q       <= pos_d;
      moved_q     <= moved_d;
    end
  end

  sc_counter_repeat #(
    .WIDTH (CNT_W)
  ) u_repeat_cnt (
    .clk_i      (SC_RegPOSJUG1_CLOCK_50),
    .rst_i      (SC_RegPOSJUG1_RESET_InHigh),
    .clr_i      (cnt_clr_s),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .dec_i      (cnt_dec_s),
    .tc_o       (cnt_tc_s)
  );

  assign SC_RegPOSJUG1_posjug1_OutBUS = pos_q;
  assign SC_RegPOSJUG1_moved_OutHigh  = moved_q;
  assign SC_RegPOSJUG1_atEdge_OutHigh = pos_q[0] | pos_q[DATAWIDTH-1];

endmodule

// File: tb/tb_sc_reg_posjug1.sv
// Self-checking bench for sc_reg_posjug1: directed scenarios plus random
// stimulus against a hold-time based position model.
module tb_sc_reg_posjug1;

  localparam int W   = 8;
  localparam int DLY = 4;
  localparam int PER = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         clr = 1'b0;
  logic         left_n = 1'b1;
  logic         right_n = 1'b1;
  logic [W-1:0] pos;
  logic         moved;
  logic         at_edge;

  int checks = 0;
  int errors = 0;

  // Model: position as an index, plus how long the current request has been held.
  int m_idx = 4;
  bit m_moved = 1'b0;
  bit m_smp_l = 1'b1;
  bit m_smp_r = 1'b1;
  bit m_hold = 1'b0;
  bit m_dir = 1'b0;
  int m_n = 0;

  always #5 clk = ~clk;

  sc_reg_posjug1 #(
    .DATAWIDTH     (W),
    .INIT_POS      (8'h10),
    .REPEAT_DELAY  (DLY),
    .REPEAT_PERIOD (PER)
  ) dut (
    .SC_RegPOSJUG1_CLOCK_50       (clk),
    .SC_RegPOSJUG1_RESET_InHigh   (rst),
    .SC_RegPOSJUG1_enable_InHigh  (en),
    .SC_RegPOSJUG1_clear_InHigh   (clr),
    .SC_RegPOSJUG1_left_InLow     (left_n),
    .SC_RegPOSJUG1_right_InLow    (right_n),
    .SC_RegPOSJUG1_posjug1_OutBUS (pos),
    .SC_RegPOSJUG1_moved_OutHigh  (moved),
    .SC_RegPOSJUG1_atEdge_OutHigh (at_edge)
  );

  function automatic logic [W-1:0] m_pos();
    logic [W-1:0] one;
    one = 8'h01;
    return one << m_idx;
  endfunction

  task automatic try_move(input bit d);
    if (d) begin
      if (m_idx < W - 1) m_idx++;
    end else begin
      if (m_idx > 0) m_idx--;
    end
  endtask

  // Advance the model by one rising edge using the pins present before it.
  task automatic model_step();
    int prev;
    bit rl;
    bit rr;
    bit d;
    prev = m_idx;
    m_moved = 1'b0;
    if (rst) begin
      m_idx = 4; m_hold = 1'b0; m_n = 0; m_smp_l = 1'b1; m_smp_r = 1'b1;
    end else begin
      rl = !m_smp_l && m_smp_r;
      rr = m_smp_l && !m_smp_r;
      if (clr) begin
        m_idx = 4; m_hold = 1'b0;
      end else if (!en) begin
        m_hold = 1'b0;
      end else if (rl || rr) begin
        d = rl;
        if (!m_hold) begin
          try_move(d); m_hold = 1'b1; m_dir = d; m_n = 0;
        end else if (d == m_dir) begin
          m_n++;
          if (m_n == DLY || (m_n > DLY && (m_n - DLY) % PER == 0)) try_move(d);
        end else begin
          m_hold = 1'b0;
        end
      end else begin
        m_hold = 1'b0;
      end
      m_moved = !clr && (m_idx != prev);
      m_smp_l = left_n;
      m_smp_r = right_n;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_clear();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic tap(input bit lft);
    if (lft) left_n = 1'b0; else right_n = 1'b0;
    tick();
    left_n = 1'b1; right_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    left_n = 1'b0;
    tick(); tick();
    checks++;
    if (pos !== 8'h10) begin errors++; $display("FAIL reset_pos got %h exp %h", pos, 8'h10); end
    checks++;
    if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved got %b exp 0", moved); end
    rst = 1'b0;
    tick();
    checks++;
    if (pos !== 8'h10) begin errors++; $display("FAIL reset_release1 got %h exp %h", pos, 8'h10); end
    tick();
    checks++;
    if (pos !== 8'h20 || moved !== 1'b1) begin
      errors++; $display("FAIL reset_release2 got %h/%b exp 20/1", pos, moved);
    end
    left_n = 1'b1; tick(); tick();
  endtask

  task automatic test_single_tap();
    int pulses;
    go_clear();
    pulses = 0;
    left_n = 1'b0; tick(); if (moved) pulses++;
    left_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (moved) pulses++; end
    checks++;
    if (pos !== 8'h20 || pulses != 1) begin
      errors++; $display("FAIL tap_left got %h pulses %0d exp 20 pulses 1", pos, pulses);
    end
    pulses = 0;
    right_n = 1'b0; tick(); if (moved) pulses++;
    right_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (moved) pulses++; end
    checks++;
    if (pos !== 8'h10 || pulses != 1) begin
      errors++; $display("FAIL tap_right got %h pulses %0d exp 10 pulses 1", pos, pulses);
    end
  endtask

  task automatic test_hold_repeat();
    logic [7:0] exp_hold [14] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04,
                                  8'h08, 8'h08, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20};
    int pulses;
    go_clear();
    for (int i = 0; i < 4; i++) tap(1'b0);
    checks++;
    if (pos !== 8'h01) begin errors++; $display("FAIL hold_start got %h exp 01", pos); end
    pulses = 0;
    left_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 12) left_n = 1'b1;
      tick();
      if (moved) pulses++;
      checks++;
      if (pos !== exp_hold[i]) begin
        errors++; $display("FAIL hold_step%0d got %h exp %h", i, pos, exp_hold[i]);
      end
    end
    checks++;
    if (pulses != 5) begin errors++; $display("FAIL hold_pulses got %0d exp 5", pulses); end
  endtask

  task automatic test_saturation();
    int pulses;
    go_clear();
    tap(1'b1); tap(1'b1);
    pulses = 0;
    left_n = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 10) left_n = 1'b1;
      tick();
      if (moved) pulses++;
      checks++;
      if (at_edge !== (m_idx == 0 || m_idx == W - 1)) begin
        errors++; $display("FAIL sat_atedge%0d got %b exp %b", i, at_edge, (m_idx == W - 1));
      end
    end
    checks++;
    if (pos !== 8'h80 || pulses != 1 || at_edge !== 1'b1) begin
      errors++; $display("FAIL sat_final got %h/%0d/%b exp 80/1/1", pos, pulses, at_edge);
    end
  endtask

  task automatic test_both_pressed();
    go_clear();
    left_n = 1'b0; right_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pos !== 8'h10 || moved !== 1'b0) begin
        errors++; $display("FAIL both_hold%0d got %h/%b exp 10/0", i, pos, moved);
      end
    end
    right_n = 1'b1;
    tick();
    checks++;
    if (pos !== 8'h10) begin errors++; $display("FAIL both_rel1 got %h exp 10", pos); end
    tick();
    checks++;
    if (pos !== 8'h20 || moved !== 1'b1) begin
      errors++; $display("FAIL both_rel2 got %h/%b exp 20/1", pos, moved);
    end
    left_n = 1'b1; tick(); tick();
  endtask

  task automatic test_enable_clear();
    go_clear();
    right_n = 1'b0;
    tick(); tick();
    checks++;
    if (pos !== 8'h08) begin errors++; $display("FAIL en_first got %h exp 08", pos); end
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (pos !== 8'h08 || moved !== 1'b0) begin
        errors++; $display("FAIL en_freeze%0d got %h/%b exp 08/0", i, pos, moved);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (pos !== 8'h04 || moved !== 1'b1) begin
      errors++; $display("FAIL en_resume got %h/%b exp 04/1", pos, moved);
    end
    for (int i = 0; i < 20 && m_idx != 1; i++) tick();
    checks++;
    if (pos !== 8'h02) begin errors++; $display("FAIL clr_reach got %h exp 02", pos); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (pos !== 8'h10 || moved !== 1'b0) begin
      errors++; $display("FAIL clr_mid got %h/%b exp 10/0", pos, moved);
    end
    tick();
    checks++;
    if (pos !== 8'h08 || moved !== 1'b1) begin
      errors++; $display("FAIL clr_repress got %h/%b exp 08/1", pos, moved);
    end
    right_n = 1'b1; tick(); tick();
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) left_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) right_n = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 29) != 0);
      clr = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      exp = m_pos();
      checks++;
      if (pos !== exp || moved !== m_moved || at_edge !== (m_idx == 0 || m_idx == W - 1)) begin
        errors++;
        $display("FAIL rand%0d got %h/%b/%b exp %h/%b/%b", i, pos, moved, at_edge,
                 exp, m_moved, (m_idx == 0 || m_idx == W - 1));
      end
    end
    rst = 1'b0; en = 1'b1; clr = 1'b0; left_n = 1'b1; right_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_tap();
    test_hold_repeat();
    test_saturation();
    test_both_pressed();
    test_enable_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_reg_posjug1.md
Name: sc_reg_posjug1

Overview:
- Player-1 position register for the row-0 collision path.
- Converts active-low left/right button levels into a one-hot position bus, posjug1.
- posjug1 feeds the player-1 position comparator directly, which compares it against obstacle row fila0.
- Supports single-step moves, hold-to-repeat, edge saturation and a game-enable freeze.

Parameters:
- DATAWIDTH, 8, width of the one-hot position bus; must equal the comparator width.
- INIT_POS, 8'b00010000, one-hot position loaded at reset and on clear.
- REPEAT_DELAY, 25000000, hold cycles after the first move before auto-repeat starts (must be >=1).
- REPEAT_PERIOD, 10000000, cycles between auto-repeat moves (must be >=1).

Ports:
- SC_RegPOSJUG1_CLOCK_50  in  1  system clock; all logic on rising edge.
- SC_RegPOSJUG1_RESET_InHigh  in  1  synchronous reset, active-high.
- SC_RegPOSJUG1_enable_InHigh  in  1  game running; low freezes the position.
- SC_RegPOSJUG1_clear_InHigh  in  1  synchronous reload of INIT_POS (new round).
- SC_RegPOSJUG1_left_InLow  in  1  left button, active-low, already debounced.
- SC_RegPOSJUG1_right_InLow  in  1  right button, active-low, already debounced.
- SC_RegPOSJUG1_posjug1_OutBUS  out  DATAWIDTH  one-hot player position, to the comparator.
- SC_RegPOSJUG1_moved_OutHigh  out  1  one-cycle pulse when the position changed.
- SC_RegPOSJUG1_atEdge_OutHigh  out  1  combinational: position is at bit 0 or at bit DATAWIDTH-1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: posjug1 = INIT_POS, moved = 0, FSM = IDLE, counter = 0, input sample registers = 1 (released).
- Input sampling: both buttons registered once (sample stage). Decisions use the sampled values only.
- Direction convention: left = shift toward the MSB; right = shift toward the LSB.
- Valid request: exactly one sampled button low.
  - Both low or both high = no request.
- FSM states: IDLE, DELAY, REPEAT. The state register also holds the current direction dir.
- IDLE:
  - Valid request: attempt a move, load counter with REPEAT_DELAY-1, go to DELAY, latch dir.
  - No valid request: stay in IDLE.
- DELAY:
  - Same direction still held: decrement counter. At 0, attempt a move, load REPEAT_PERIOD-1, go to REPEAT.
  - Release, both pressed, or direction change: go to IDLE with no move. A new request is taken on the following cycle.
- REPEAT: same as DELAY, but at 0 attempt a move and reload REPEAT_PERIOD-1, staying in REPEAT.
- Move attempt and saturation:
  - At bit DATAWIDTH-1, a left attempt changes nothing; same for a right attempt at bit 0.
  - There is no wrap-around.
  - moved pulses only when posjug1 actually changes.
  - A saturated attempt still advances the FSM normally.
- Latency: button change sampled at edge N; posjug1 and moved update at edge N+1. Total two edges from pin to bus.
- moved is high for exactly one cycle per change.
- Enable low:
  - posjug1 holds, FSM forced to IDLE, counter cleared, moved = 0.
  - When enable returns high with a button held, that counts as a new press: immediate move.
- Clear: overrides the move logic. posjug1 = INIT_POS, FSM = IDLE, moved = 0. Priority is reset > clear > enable.
- posjug1 is always exactly one-hot. No state, including reset mid-repeat, may produce zero or multiple ones.
- Counter width: $clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD, minimum 1.

Decomposition:
- Shared game package:
  - Bus width constant (8) and default INIT_POS, shared with the comparator and the row generator.
  - FSM state encoding (IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2).
  - Direction encoding (LEFT = 1'b1, RIGHT = 1'b0).
- One natural sub-module: sc_counter_repeat, a loadable down-counter with a terminal-count flag. It is reusable for the obstacle-row shift timer.

Test Plan (DATAWIDTH=8, INIT_POS=8'h10, REPEAT_DELAY=4, REPEAT_PERIOD=2):
- Reset: hold RESET_InHigh high for 2 cycles with left pressed -> posjug1 = 8'h10, moved = 0. After release, posjug1 = 8'h20 two edges later.
- Single tap: left low for 1 cycle -> posjug1 8'h10 -> 8'h20, exactly one moved pulse. Right tap then -> 8'h10.
- Hold left 12 cycles from 8'h01 -> moves at t+1, then at t+5, t+7, t+9, t+11: 8'h02, 8'h04, 8'h08, 8'h10, 8'h20.
- Saturation: start 8'h40, hold left 10 cycles -> 8'h80 once, then no change. moved pulses once; atEdge = 1 from 8'h80 onward.
- Both buttons low from 8'h10 -> no move, FSM IDLE, moved = 0. Release right while left stays low -> 8'h20 two edges later.
- Enable and clear:
  - Enable low while holding right -> posjug1 frozen.
  - Enable high again -> immediate move.
  - Clear mid-REPEAT at 8'h02 -> 8'h10 next edge, moved = 0, FSM IDLE.
